// File: rtl/lfsr_pair_sequencer.sv
// Pairs successive decoded LFSR words and runs one polynomial_finder cycle per
// eligible (older, newer) pair, publishing one result record per run.
module lfsr_pair_sequencer #(
  parameter logic [23:0] MAX_GAP         = 24'd40000,
  parameter logic [15:0] TIMEOUT_CYCLES  = 16'd8192,
  parameter int unsigned COOLDOWN_CYCLES = 2
) (
  input  logic        clk_96MHz,
  input  logic        reset_n,
  input  logic        data_valid,
  input  logic [16:0] data_in,
  input  logic [23:0] ts_in,
  input  logic        finder_ready,
  input  logic [16:0] finder_polynomial,
  input  logic [16:0] finder_iteration,
  output logic        finder_enable,
  output logic [16:0] finder_data0,
  output logic [16:0] finder_data1,
  output logic [23:0] finder_ts0,
  output logic [23:0] finder_ts1,
  output logic        result_valid,
  output logic [16:0] result_polynomial,
  output logic [16:0] result_iteration,
  output logic [23:0] result_ts,
  output logic        result_timeout,
  output logic [7:0]  drop_count,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_EMPTY    = 3'd0,
    S_ONE      = 3'd1,
    S_CHECK    = 3'd2,
    S_ARM      = 3'd3,
    S_BUSY     = 3'd4,
    S_CAPTURE  = 3'd5,
    S_COOLDOWN = 3'd6,
    S_SHIFT    = 3'd7
  } state_t;

  localparam logic [15:0] TO_LAST = TIMEOUT_CYCLES - 16'd1;
  localparam logic [7:0]  CD_LAST = 8'(COOLDOWN_CYCLES - 1);

  state_t      state;
  logic [16:0] pend_data;
  logic [23:0] pend_ts;
  logic        pend_valid;
  logic [15:0] busy_cnt;
  logic [7:0]  cd_cnt;
  logic [23:0] gap;
  logic        eligible;
  logic        pend_store;

  // Modulo-2^24 subtraction keeps the gap correct across timestamp wrap.
  assign gap        = finder_ts1 - finder_ts0;
  assign eligible   = (gap <= MAX_GAP) && (gap != 24'd0) && (finder_data0 != finder_data1);
  assign pend_store = data_valid && (state inside {S_CHECK, S_ARM, S_BUSY, S_CAPTURE, S_COOLDOWN});
  assign dbg_state  = state;

  // Finder handshake: enable rises with inputs already stable; ready=1 seen on
  // the rise cycle is stale, so we wait for ready to fall, then for it to rise
  // again, and latch outputs while enable is still high (finder zeroes them
  // once enable falls). result_valid is a single-cycle strobe with no stall.
  always_ff @(posedge clk_96MHz or negedge reset_n) begin
    if (!reset_n) begin
      state             <= S_EMPTY;
      finder_enable     <= 1'b0;
      finder_data0      <= '0;
      finder_data1      <= '0;
      finder_ts0        <= '0;
      finder_ts1        <= '0;
      pend_data         <= '0;
      pend_ts           <= '0;
      pend_valid        <= 1'b0;
      busy_cnt          <= '0;
      cd_cnt            <= '0;
      result_valid      <= 1'b0;
      result_polynomial <= '0;
      result_iteration  <= '0;
      result_ts         <= '0;
      result_timeout    <= 1'b0;
      drop_count        <= '0;
    end else begin
      result_valid <= 1'b0;

      if (pend_store) begin
        pend_data  <= data_in;
        pend_ts    <= ts_in;
        pend_valid <= 1'b1;
        if (pend_valid && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end

      case (state)
        S_EMPTY: begin
          if (data_valid) begin
            finder_data1 <= data_in;
            finder_ts1   <= ts_in;
            state        <= S_ONE;
          end
        end
        S_ONE: begin
          // A word parked by SHIFT while going idle is consumed before new input.
          if (pend_valid) begin
            finder_data0 <= finder_data1;
            finder_ts0   <= finder_ts1;
            finder_data1 <= pend_data;
            finder_ts1   <= pend_ts;
            pend_valid   <= data_valid;
            pend_data    <= data_in;
            pend_ts      <= ts_in;
            state        <= S_CHECK;
          end else if (data_valid) begin
            finder_data0 <= finder_data1;
            finder_ts0   <= finder_ts1;
            finder_data1 <= data_in;
            finder_ts1   <= ts_in;
            state        <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (eligible) begin
            finder_enable <= 1'b1;
            state         <= S_ARM;
          end else begin
            state <= S_SHIFT;
          end
        end
        S_ARM: begin
          if (!finder_ready) begin
            busy_cnt <= '0;
            state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (finder_ready) begin
            result_polynomial <= finder_polynomial;
            result_iteration  <= finder_iteration;
            result_ts         <= finder_ts0;
            result_timeout    <= 1'b0;
            result_valid      <= 1'b1;
            state             <= S_CAPTURE;
          end else if (busy_cnt == TO_LAST) begin
            result_polynomial <= '0;
            result_iteration  <= '0;
            result_ts         <= finder_ts0;
            result_timeout    <= 1'b1;
            result_valid      <= 1'b1;
            state             <= S_CAPTURE;
          end else begin
            busy_cnt <= busy_cnt + 16'd1;
          end
        end
        S_CAPTURE: begin
          finder_enable <= 1'b0;
          cd_cnt        <= '0;
          state         <= S_COOLDOWN;
        end
        S_COOLDOWN: begin
          if (cd_cnt == CD_LAST) state <= S_SHIFT;
          else cd_cnt <= cd_cnt + 8'd1;
        end
        S_SHIFT: begin
          if (pend_valid) begin
            finder_data0 <= finder_data1;
            finder_ts0   <= finder_ts1;
            finder_data1 <= pend_data;
            finder_ts1   <= pend_ts;
            pend_valid   <= data_valid;
            pend_data    <= data_in;
            pend_ts      <= ts_in;
            state        <= S_CHECK;
          end else begin
            if (data_valid) begin
              pend_data  <= data_in;
              pend_ts    <= ts_in;
              pend_valid <= 1'b1;
            end
            state <= S_ONE;
          end
        end
        default: state <= S_EMPTY;
      endcase
    end
  end

endmodule
